// File: rtl/lsu_if.sv
// Request/response and data-memory port bundle for the load/store control stage.
// Handshake: a request transfers on a rising clk edge where req_valid and req_ready are both 1;
// resp_valid is a one-cycle pulse with no back-pressure, and resp_err/resp_rdata are read only with it.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [XLEN-1:0]   mem_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_data, mem_read, mem_write, mem_size, mem_unsigned
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_data, mem_read, mem_write, mem_size, mem_unsigned
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the word-organised data memory.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned halfword/word accesses into byte accesses.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e state, state_n;

  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;

  logic accept;
  logic misalign;
  logic req_bad;
  logic split_run;
  logic last_byte;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign dbg_state = state;

  always_comb begin
    misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_q;
  logic [1:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] acc_n;

  assign req_bad   = (bus.req_size == 2'b11);
  assign split_run = split_q;
  assign last_byte = (cnt_q == ((size_q == 2'b01) ? 2'd1 : 2'd3));

  // Accumulator view including the byte arriving this cycle, so the exit edge sees all bytes.
  always_comb begin
    acc_n = acc_q;
    acc_n[{cnt_q, 3'b000} +: 8] = bus.mem_out[7:0];
  end
`else
  assign req_bad   = (bus.req_size == 2'b11) || misalign;
  assign split_run = 1'b0;
  assign last_byte = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n          = state;
    bus.req_ready    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data     = '0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_size     = 2'b00;
    bus.mem_unsigned = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_n = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_read  = !we_q;
        bus.mem_write = we_q;
        if (split_run) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          bus.mem_addr     = addr_q + ADDR_W'(cnt_q);
          bus.mem_data     = {{(XLEN-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
          bus.mem_size     = 2'b00;
          bus.mem_unsigned = 1'b1;
`endif
          if (last_byte) state_n = RESP;
        end else begin
          bus.mem_addr     = addr_q;
          bus.mem_data     = wdata_q;
          bus.mem_size     = size_q;
          bus.mem_unsigned = uns_q;
          state_n          = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      err_q          <= 1'b0;
      size_q         <= 2'b00;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q        <= 1'b0;
      cnt_q          <= 2'd0;
      acc_q          <= '0;
`endif
    end else begin
      bus.resp_valid <= (state == RESP);
      bus.resp_err   <= (state == RESP) && err_q;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_bad;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_q <= misalign && !req_bad;
        cnt_q   <= 2'd0;
`endif
      end
      if (state == ACCESS && !we_q) begin
        if (!split_run) bus.resp_rdata <= bus.mem_out;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state == ACCESS && split_run) begin
        acc_q <= acc_n;
        cnt_q <= cnt_q + 2'd1;
        if (last_byte && !we_q) begin
          if (size_q == 2'b01)
            bus.resp_rdata <= {{(XLEN-16){!uns_q && acc_n[15]}}, acc_n[15:0]};
          else
            bus.resp_rdata <= XLEN'(acc_n);
        end
      end
`endif
      // Stores and rejected requests always report zero data.
      if (state == RESP && (err_q || we_q)) bus.resp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a little-endian byte memory model on the mem_* port.
// Split-mode checks are selected by LSU_MISALIGN_SPLIT_EN, matching the design build.
module tb_lsu_ctrl;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  lsu_if #(.ADDR_W(32), .XLEN(32)) bus ();

  lsu_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 bytes indexed by the low address byte.
  logic [7:0]  m [0:255];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] ws_q[$];
  logic [31:0] exp_q[$];
  int          rd_cnt = 0;
  logic [7:0]  i0, i1, i2, i3;

  always_comb begin
    i0 = bus.mem_addr[7:0];
    i1 = i0 + 8'd1;
    i2 = i0 + 8'd2;
    i3 = i0 + 8'd3;
    case (bus.mem_size)
      2'b00:   bus.mem_out = bus.mem_unsigned ? {24'b0, m[i0]} : {{24{m[i0][7]}}, m[i0]};
      2'b01:   bus.mem_out = bus.mem_unsigned ? {16'b0, m[i1], m[i0]}
                                              : {{16{m[i1][7]}}, m[i1], m[i0]};
      default: bus.mem_out = {m[i3], m[i2], m[i1], m[i0]};
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_read) rd_cnt <= rd_cnt + 1;
    if (bus.mem_write) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_data);
      ws_q.push_back({30'b0, bus.mem_size});
      m[i0] <= bus.mem_data[7:0];
      if (bus.mem_size != 2'b00) m[i1] <= bus.mem_data[15:8];
      if (bus.mem_size == 2'b10) begin
        m[i2] <= bus.mem_data[23:16];
        m[i3] <= bus.mem_data[31:24];
      end
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request, then waits (bounded) for the response pulse.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic rdy_low);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rdy_low = !bus.req_ready;
    lat   = 0;
    rdata = 'x;
    err   = 1'bx;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.resp_valid) begin
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
      if (bus.req_ready) rdy_low = 1'b0;
    end
  endtask

  int          lat;
  int          wbase;
  int          rbase;
  logic [31:0] rdata;
  logic        err;
  logic        rdy_low;

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_ctl", {28'b0, bus.mem_read, bus.mem_write, bus.mem_size}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store then load.
    wbase = wa_q.size();
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    check("sw_lat", lat, 32'd2);
    check("sw_err", {31'b0, err}, 32'd0);
    check("sw_rdata", rdata, 32'd0);
    check("sw_nwr", wa_q.size() - wbase, 32'd1);
    if (wa_q.size() > wbase) begin
      check("sw_wr_addr", wa_q[wbase], 32'h10);
      check("sw_wr_data", wd_q[wbase], 32'hDEADBEEF);
      check("sw_wr_size", ws_q[wbase], 32'd2);
    end
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    check("lw_err", {31'b0, err}, 32'd0);
    check("lw_ready_low", {31'b0, rdy_low}, 32'd1);
    @(posedge clk);
    #1;
    check("resp_pulse_one_cycle", {31'b0, bus.resp_valid}, 32'd0);

    // Extension of byte/halfword loads.
    do_req(1'b1, 32'h10, 32'h8000FF80, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    do_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, lat, rdata, err, rdy_low);
    check("lb_signed", rdata, 32'hFFFFFF80);
    do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, lat, rdata, err, rdy_low);
    check("lhu_12", rdata, 32'h00008000);
    do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, lat, rdata, err, rdy_low);
    check("lh_12", rdata, 32'hFFFF8000);
    check("lh_12_lat", lat, 32'd2);

    // Illegal size.
    rbase = rd_cnt;
    wbase = wa_q.size();
    do_req(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, lat, rdata, err, rdy_low);
    check("ill_err", {31'b0, err}, 32'd1);
    check("ill_lat", lat, 32'd1);
    check("ill_rdata", rdata, 32'd0);
    check("ill_no_mem", (rd_cnt - rbase) + (wa_q.size() - wbase), 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    wbase = wa_q.size();
    do_req(1'b1, 32'h21, 32'h11223344, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    check("ssw_lat", lat, 32'd5);
    check("ssw_nwr", wa_q.size() - wbase, 32'd4);
    exp_q = '{32'h21, 32'h44, 32'h22, 32'h33, 32'h23, 32'h22, 32'h24, 32'h11};
    for (int k = 0; k < 4; k++) begin
      if (wa_q.size() > wbase + k) begin
        check("ssw_addr", wa_q[wbase+k], exp_q.pop_front());
        check("ssw_data", wd_q[wbase+k], exp_q.pop_front());
        check("ssw_size", ws_q[wbase+k], 32'd0);
      end
    end
    do_req(1'b0, 32'h21, 32'h0, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    check("slw_rdata", rdata, 32'h11223344);
    check("slw_lat", lat, 32'd5);
    check("slw_err", {31'b0, err}, 32'd0);
    check("slw_ready_low", {31'b0, rdy_low}, 32'd1);
    do_req(1'b1, 32'h31, 32'h0000ABCD, 2'b01, 1'b0, lat, rdata, err, rdy_low);
    check("ssh_lat", lat, 32'd3);
    do_req(1'b0, 32'h31, 32'h0, 2'b01, 1'b0, lat, rdata, err, rdy_low);
    check("slh_signed", rdata, 32'hFFFFABCD);
    check("slh_lat", lat, 32'd3);
    do_req(1'b0, 32'h31, 32'h0, 2'b01, 1'b1, lat, rdata, err, rdy_low);
    check("slhu", rdata, 32'h0000ABCD);
    wbase = wa_q.size();
    do_req(1'b1, 32'hFFFFFFFE, 32'hCAFEF00D, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    exp_q = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    check("wrap_nwr", wa_q.size() - wbase, 32'd4);
    for (int k = 0; k < 4; k++)
      if (wa_q.size() > wbase + k) check("wrap_addr", wa_q[wbase+k], exp_q.pop_front());

    // Reset in the second byte cycle of a split store.
    wbase = wa_q.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h41;
    bus.req_wdata = 32'hA1B2C3D4;
    bus.req_size  = 2'b10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_pre_addr", bus.mem_addr, 32'h42);
    check("rstmid_pre_wr", {31'b0, bus.mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_wr", {31'b0, bus.mem_write}, 32'd0);
    check("rstmid_nwr", wa_q.size() - wbase, 32'd1);
    check("rstmid_byte_kept", {24'b0, m[8'h41]}, 32'hD4);
`else
    rbase = rd_cnt;
    wbase = wa_q.size();
    do_req(1'b0, 32'h13, 32'h0, 2'b01, 1'b0, lat, rdata, err, rdy_low);
    check("mis_lh_err", {31'b0, err}, 32'd1);
    check("mis_lh_lat", lat, 32'd1);
    check("mis_lh_rdata", rdata, 32'd0);
    do_req(1'b1, 32'h21, 32'h11223344, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    check("mis_sw_err", {31'b0, err}, 32'd1);
    check("mis_no_mem", (rd_cnt - rbase) + (wa_q.size() - wbase), 32'd0);

    // Reset in the access cycle of an aligned store.
    wbase = wa_q.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h44;
    bus.req_wdata = 32'hA1B2C3D4;
    bus.req_size  = 2'b10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rstmid_pre_wr", {31'b0, bus.mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_wr", {31'b0, bus.mem_write}, 32'd0);
    @(posedge clk);
    #1;
    check("rstmid_nwr", wa_q.size() - wbase, 32'd0);
`endif
    check("rstmid_addr", bus.mem_addr, 32'd0);
    check("rstmid_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rstmid_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, rdata, err, rdy_low);
    check("post_rst_lw", rdata, 32'h8000FF80);
    check("post_rst_lat", lat, 32'd2);
    check("post_rst_err", {31'b0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store control stage directly upstream of the word-organised data memory. Accepts one load/store request at a time from the execute/memory pipeline stage via a valid/ready handshake. Drives the memory's addr/data/read/write/size/unsigned port set and returns a registered load result or store completion. Misaligned halfword/word accesses are either split into sequential byte accesses or rejected, depending on a compile-time option.

Parameters:
- ADDR_W, 32, request and memory address width.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data; low bytes used for byte/halfword
- req_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal
- req_unsigned  in  1  1=zero-extend load, 0=sign-extend
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; illegal size or rejected misalign
- mem_addr  out  ADDR_W  memory byte address
- mem_data  out  XLEN  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable; memory writes on the clk edge
- mem_size  out  2  memory access size
- mem_unsigned  out  1  memory extension control
- mem_out  in  XLEN  combinational memory read data

Behaviour:
- Reset: clk and rst_n only; rst_n is asynchronous and active-low. State=IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0. All mem_* outputs=0. Assertion mid-operation aborts at once, with no further memory writes; a byte already written stays written.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, capture addr, wdata, we, size and unsigned into registers.
  - Misaligned = (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
  - size==11, or misaligned with split disabled: go to RESP with err=1 and no memory access.
  - Otherwise: go to ACCESS with byte counter cnt=0 and split flag set if misaligned.
- req_ready=0 in ACCESS and RESP. There is no back-pressure on the response.
- mem_* outputs are combinational from state and the captured registers. They are nonzero only in ACCESS.
- ACCESS, aligned:
  - Drive mem_addr=addr, mem_size=size, mem_unsigned=unsigned, mem_data=wdata, and mem_read=!we or mem_write=we.
  - Load: resp_rdata <= mem_out at the end of the cycle.
  - Go to RESP after 1 cycle.
- ACCESS, split:
  - N = 2 for halfword, 4 for word.
  - Each cycle: mem_addr = addr+cnt (modulo 2^ADDR_W, wraps through 0xFFFFFFFF→0), mem_size=00, mem_unsigned=1.
  - Store: mem_data = {24'b0, wdata[8*cnt+:8]}.
  - Load: acc[8*cnt+:8] <= mem_out[7:0].
  - cnt increments each cycle. When cnt==N-1, go to RESP.
  - On the exit edge, halfword loads extend acc[15:0] per unsigned; word loads take acc as-is.
- RESP: resp_valid=1 for exactly one cycle, resp_err as decided, then go to IDLE. resp_rdata holds its value until the next response.
- Stores and errors return resp_rdata=0.
- Latency, counted from the accepting edge to resp_valid high: aligned 2 cycles; split halfword 3; split word 5; error 1.
- A new request can be accepted in the cycle after RESP.
- Simultaneous req_valid during ACCESS/RESP is ignored; the requester holds the request until it sees req_ready.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned halfword/word accesses are split into byte accesses as above.
- Undefined: misaligned accesses return resp_err=1 with resp_rdata=0 after 1 cycle, and mem_read/mem_write are never asserted. The split counter and accumulator are not instantiated.

Test Plan:
- Aligned word store addr 0x10, data 0xDEADBEEF; then word load 0x10 → one mem_write cycle with size 10; load returns 0xDEADBEEF, resp_valid 2 cycles after acceptance, resp_err=0.
- Memory word 0x10 = 0x8000FF80. Signed byte load at 0x10 → 0xFFFFFF80. Unsigned halfword load at 0x12 → 0x00008000. Signed halfword load at 0x12 → 0xFFFF8000.
- Split enabled: word store 0x11223344 to 0x21 → byte writes 0x44,0x33,0x22,0x11 at 0x21..0x24. Word load from 0x21 → 0x11223344, latency 5, req_ready low throughout.
- Split disabled: halfword load at 0x13 → resp_err=1 after 1 cycle, rdata=0, no mem_read/mem_write. req_size=11 → resp_err=1 in both builds.
- Split word store at 0xFFFFFFFE → mem_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- rst_n asserted in the 2nd byte cycle of a split store → mem_write drops immediately, outputs zero, req_ready=1. After release, a fresh aligned load completes normally.
